// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sharing of one W-bit add/subtract unit among N requesters,
// with results returned tagged by requester ID through a one-entry response register.
module adder_arbiter #(
    parameter int N   = 4,
    parameter int W   = 8,
    parameter int IDW = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req_valid,
    output logic [N-1:0]   req_ready,
    input  logic [N-1:0]   req_op,
    input  logic [N*W-1:0] req_a,
    input  logic [N*W-1:0] req_b,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [W-1:0]   rsp_data,
    output logic [IDW-1:0] rsp_id,
    output logic           rsp_op
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t         state_q, state_d;
    logic [W-1:0]   data_q, data_d;
    logic [IDW-1:0] id_q, id_d, ptr_q, ptr_d;
    logic           op_q, op_d;
    logic [IDW-1:0] gnt, idx;
    logic           found, accept, op;
    logic [W-1:0]   a, b;
    // first valid requester at or after ptr_q, wrapping modulo N
    always_comb begin
        found = 1'b0;
        gnt = '0;
        idx = '0;
        for (int k = 0; k < N; k++) begin
            idx = IDW'((int'(ptr_q) + k) % N);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gnt = idx;
            end
        end
    end
    always_comb begin
        a = '0;
        b = '0;
        op = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (IDW'(k) == gnt) begin
                a = req_a[k*W +: W];
                b = req_b[k*W +: W];
                op = req_op[k];
            end
        end
    end
    always_comb begin
        accept = (state_q == EMPTY || rsp_ready) && found;
        req_ready = accept ? N'(1) << gnt : '0;
        state_d = accept ? FULL : (rsp_ready ? EMPTY : state_q);
        data_d = accept ? (op ? b - a : a + b) : data_q;
        id_d = accept ? gnt : id_q;
        op_d = accept ? op : op_q;
        ptr_d = accept ? (gnt == IDW'(N - 1) ? '0 : gnt + 1'b1) : ptr_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            data_q <= '0;
            id_q <= '0;
            op_q <= 1'b0;
            ptr_q <= '0;
        end else begin
            state_q <= state_d;
            data_q <= data_d;
            id_q <= id_d;
            op_q <= op_d;
            ptr_q <= ptr_d;
        end
    end
    assign rsp_valid = (state_q == FULL);
    assign rsp_data = data_q;
    assign rsp_id = id_q;
    assign rsp_op = op_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed and randomized checks of adder_arbiter against a
// transaction-level model of grant order, arithmetic and response register contents.
module tb_adder_arbiter;
    localparam int N = 4;
    localparam int W = 8;
    localparam int IDW = 2;
    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   req_op = '0;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [W-1:0]   rsp_data;
    logic [IDW-1:0] rsp_id;
    logic           rsp_op;
    int checks = 0;
    int failures = 0;
    logic         m_valid = 1'b0;
    logic [W-1:0] m_data = '0;
    int           m_id = 0;
    logic         m_op = 1'b0;
    int           m_ptr = 0;
    bit           hold_all = 1'b0;

    adder_arbiter #(.N(N), .W(W), .IDW(IDW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_op(rsp_op)
    );

    always #5 clk = ~clk;

    function automatic int grant();
        for (int k = 0; k < N; k++)
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int g = grant();
        return ((!m_valid || rsp_ready) && g >= 0) ? N'(1) << g : '0;
    endfunction

    function automatic logic [W+IDW+1:0] exp_rsp();
        return {m_valid, m_data, IDW'(m_id), m_op};
    endfunction

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_op[i] = op;
        req_valid[i] = 1'b1;
    endtask

    task automatic tick();
        int g;
        logic acc, nop;
        logic [W-1:0] av, bv;
        g = grant();
        acc = (!m_valid || rsp_ready) && g >= 0;
        av = '0; bv = '0; nop = 1'b0;
        if (acc) begin
            av = req_a[g*W +: W];
            bv = req_b[g*W +: W];
            nop = req_op[g];
        end
        @(posedge clk);
        #1;
        if (acc) begin
            m_valid = 1'b1;
            m_data = nop ? bv - av : av + bv;
            m_id = g;
            m_op = nop;
            m_ptr = (g + 1) % N;
            if (!hold_all) req_valid[g] = 1'b0;
        end else if (rsp_ready) m_valid = 1'b0;
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        req_valid = '0;
        m_valid = 1'b0; m_data = '0; m_id = 0; m_op = 1'b0; m_ptr = 0;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({rsp_valid, rsp_data, rsp_id, rsp_op} !== '0) begin
            failures++;
            $display("FAIL reset_rsp: got %h expected 0", {rsp_valid, rsp_data, rsp_id, rsp_op});
        end
        checks++;
        if (req_ready !== '0) begin
            failures++;
            $display("FAIL reset_ready: got %b expected 0", req_ready);
        end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_single_add();
        rsp_ready = 1'b1;
        set_req(2, 8'd4, 8'd7, 1'b0);
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL add_ready: got %b expected 0100", req_ready);
        end
        tick();
        checks++;
        if ({rsp_valid, rsp_data, rsp_id, rsp_op} !== {1'b1, 8'd11, 2'd2, 1'b0}) begin
            failures++;
            $display("FAIL add_rsp: got %h expected %h", {rsp_valid, rsp_data, rsp_id, rsp_op}, {1'b1, 8'd11, 2'd2, 1'b0});
        end
    endtask

    task automatic test_subtract_wrap();
        set_req(1, 8'd12, 8'd8, 1'b1);
        #1;
        checks++;
        if (req_ready !== exp_ready()) begin
            failures++;
            $display("FAIL sub_ready: got %b expected %b", req_ready, exp_ready());
        end
        tick();
        checks++;
        if (rsp_data !== 8'hFC || {rsp_valid, rsp_data, rsp_id, rsp_op} !== exp_rsp()) begin
            failures++;
            $display("FAIL sub_rsp: got %h expected %h", {rsp_valid, rsp_data, rsp_id, rsp_op}, exp_rsp());
        end
        set_req(0, 8'hF0, 8'h20, 1'b0);
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL addwrap_ready: got %b expected 0001", req_ready);
        end
        tick();
        checks++;
        if (rsp_data !== 8'h10 || {rsp_valid, rsp_data, rsp_id, rsp_op} !== exp_rsp()) begin
            failures++;
            $display("FAIL addwrap_rsp: got %h expected %h", {rsp_valid, rsp_data, rsp_id, rsp_op}, exp_rsp());
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        rsp_ready = 1'b1;
        hold_all = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, W'(i), 8'd10, 1'b0);
        for (int c = 0; c < 8; c++) begin
            #1;
            checks++;
            if (req_ready !== N'(1) << (c % N) || req_ready !== exp_ready()) begin
                failures++;
                $display("FAIL rr_ready[%0d]: got %b expected %b", c, req_ready, N'(1) << (c % N));
            end
            tick();
            checks++;
            if (rsp_id !== IDW'(c % N) || rsp_data !== W'(10 + c % N) || {rsp_valid, rsp_data, rsp_id, rsp_op} !== exp_rsp()) begin
                failures++;
                $display("FAIL rr_rsp[%0d]: got id=%0d data=%0d expected id=%0d data=%0d", c, rsp_id, rsp_data, c % N, 10 + c % N);
            end
        end
        hold_all = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        logic [W+IDW+1:0] snap;
        rsp_ready = 1'b1;
        set_req(0, 8'd1, 8'd2, 1'b0);
        tick();
        rsp_ready = 1'b0;
        set_req(1, 8'd20, 8'd30, 1'b1);
        set_req(3, 8'd5, 8'd9, 1'b0);
        snap = {rsp_valid, rsp_data, rsp_id, rsp_op};
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (req_ready !== '0) begin
                failures++;
                $display("FAIL bp_ready[%0d]: got %b expected 0000", c, req_ready);
            end
            tick();
            checks++;
            if ({rsp_valid, rsp_data, rsp_id, rsp_op} !== snap || snap !== exp_rsp()) begin
                failures++;
                $display("FAIL bp_hold[%0d]: got %h expected %h", c, {rsp_valid, rsp_data, rsp_id, rsp_op}, exp_rsp());
            end
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL bp_release_ready: got %b expected 0010", req_ready);
        end
        tick();
        checks++;
        if (rsp_id !== 2'd1 || {rsp_valid, rsp_data, rsp_id, rsp_op} !== exp_rsp()) begin
            failures++;
            $display("FAIL bp_release_rsp: got %h expected %h", {rsp_valid, rsp_data, rsp_id, rsp_op}, exp_rsp());
        end
        tick();
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || {rsp_valid, rsp_data, rsp_id, rsp_op} !== exp_rsp()) begin
            failures++;
            $display("FAIL bp_drain: got %h expected %h", {rsp_valid, rsp_data, rsp_id, rsp_op}, exp_rsp());
        end
    endtask

    task automatic test_sparse();
        rsp_ready = 1'b1;
        set_req(3, 8'd3, 8'd3, 1'b0);
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            failures++;
            $display("FAIL sparse_ready3: got %b expected 1000", req_ready);
        end
        tick();
        set_req(0, 8'd7, 8'd1, 1'b1);
        #1;
        checks++;
        if (req_ready !== 4'b0001 || rsp_id !== 2'd3 || rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL sparse_ready0: got ready=%b id=%0d expected ready=0001 id=3", req_ready, rsp_id);
        end
        tick();
        checks++;
        if ({rsp_valid, rsp_data, rsp_id, rsp_op} !== {1'b1, 8'hFA, 2'd0, 1'b1}) begin
            failures++;
            $display("FAIL sparse_rsp0: got %h expected %h", {rsp_valid, rsp_data, rsp_id, rsp_op}, {1'b1, 8'hFA, 2'd0, 1'b1});
        end
        for (int i = 0; i < N; i++) set_req(i, 8'd1, 8'd1, 1'b0);
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL sparse_ptr: got %b expected 0010", req_ready);
        end
        tick();
        req_valid = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b1;
        set_req(0, 8'd5, 8'd6, 1'b0);
        tick();
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (rsp_data !== 8'h0B || rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre: got valid=%b data=%h expected valid=1 data=0b", rsp_valid, rsp_data);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== '0) begin
            failures++;
            $display("FAIL rstmid_async: got valid=%b data=%h expected valid=0 data=00", rsp_valid, rsp_data);
        end
        m_valid = 1'b0; m_data = '0; m_id = 0; m_op = 1'b0; m_ptr = 0;
        @(posedge clk);
        #1 reset = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 8'd2, 8'd3, 1'b0);
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL rstmid_first: got %b expected 0001", req_ready);
        end
        tick();
        req_valid = '0;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++)
                if (!req_valid[i] && $urandom_range(0, 1) == 1)
                    set_req(i, W'($urandom), W'($urandom), 1'($urandom));
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            checks++;
            if (req_ready !== exp_ready()) begin
                failures++;
                $display("FAIL rand_ready[%0d]: got %b expected %b", c, req_ready, exp_ready());
            end
            tick();
            checks++;
            if ({rsp_valid, rsp_data, rsp_id, rsp_op} !== exp_rsp()) begin
                failures++;
                $display("FAIL rand_rsp[%0d]: got %h expected %h", c, {rsp_valid, rsp_data, rsp_id, rsp_op}, exp_rsp());
            end
        end
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_subtract_wrap();
        test_round_robin();
        test_backpressure();
        test_sparse();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
